// File: rtl/step_run_controller_pkg.sv
// Shared constants for the step/run controller: FSM state encoding and default sizes.
// Also reused by the clock divider and the core's debug readout.
package step_run_controller_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_STEP   = 2'b10;
    localparam logic [1:0] ST_HALTED = 2'b11;

    localparam int DEB_TICKS_DEF = 4;
    localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/step_run_controller_if.sv
// Signal bundle between the board/divider/core side and the step/run controller.
// Optional cycle_limit input exists only when STEP_RUN_CYCLE_LIMIT_EN is defined.
interface step_run_controller_if
    import step_run_controller_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    // tick is a one-clock pulse; cpu_en is a one-clock pulse; no backpressure anywhere.
    logic             tick;
    logic             run_sw;
    logic             step_btn;
    logic             halt_req;
`ifdef STEP_RUN_CYCLE_LIMIT_EN
    logic [CNT_W-1:0] cycle_limit;
`endif
    logic             cpu_en;
    logic [1:0]       state;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

`ifdef STEP_RUN_CYCLE_LIMIT_EN
    modport master (output tick, run_sw, step_btn, halt_req, cycle_limit,
                    input  cpu_en, state, halted, cycle_count);
    modport slave  (input  tick, run_sw, step_btn, halt_req, cycle_limit,
                    output cpu_en, state, halted, cycle_count);
`else
    modport master (output tick, run_sw, step_btn, halt_req,
                    input  cpu_en, state, halted, cycle_count);
    modport slave  (input  tick, run_sw, step_btn, halt_req,
                    output cpu_en, state, halted, cycle_count);
`endif

endinterface

// File: rtl/step_run_controller_btn_debounce.sv
// Two-flop synchronizer plus tick-qualified debounce; emits the debounced level
// and a pulse on the same edge the debounced level rises.
module btn_debounce #(
    parameter int DEB_TICKS = 4
) (
    input  logic clock,
    input  logic _rst,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_db,
    output logic rise
);
    localparam int            DW       = $clog2(DEB_TICKS);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEB_TICKS - 1);

    logic          meta_q;
    logic          sync_q;
    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] deb_cnt_d;
    logic          btn_db_q;
    logic          btn_db_d;

    always_comb begin
        btn_db_d  = btn_db_q;
        deb_cnt_d = deb_cnt_q;
        rise      = 1'b0;
        if (tick) begin
            if (sync_q != btn_db_q) begin
                // The level must differ on DEB_TICKS consecutive ticks before it is accepted.
                if (deb_cnt_q == CNT_LAST) begin
                    btn_db_d  = sync_q;
                    deb_cnt_d = '0;
                    rise      = sync_q;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end else begin
                deb_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge _rst) begin
        if (!_rst) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            deb_cnt_q <= '0;
            btn_db_q  <= 1'b0;
        end else begin
            meta_q    <= btn_raw;
            sync_q    <= meta_q;
            deb_cnt_q <= deb_cnt_d;
            btn_db_q  <= btn_db_d;
        end
    end

    assign btn_db = btn_db_q;

endmodule

// File: rtl/step_run_controller.sv
// Gates the core's pipeline enable from the divider tick: free-run, debounced single-step
// and halt modes. Optional cycle limit in RUN when STEP_RUN_CYCLE_LIMIT_EN is defined.
module step_run_controller
    import step_run_controller_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clock,
    input  logic _rst,
    step_run_controller_if.slave bus
);
    logic             run_meta_q;
    logic             run_s_q;
    logic             btn_db;
    logic             btn_rise;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             step_req_q;
    logic             step_req_d;
    logic             cpu_en_q;
    logic             cpu_en_d;
    logic             halted_q;
    logic             halted_d;
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_step_deb (
        .clock   (clock),
        ._rst    (_rst),
        .tick    (bus.tick),
        .btn_raw (bus.step_btn),
        .btn_db  (btn_db),
        .rise    (btn_rise)
    );

    always_comb begin
        state_d    = state_q;
        cpu_en_d   = 1'b0;
        step_req_d = step_req_q | btn_rise;
        case (state_q)
            ST_IDLE: begin
                if (run_s_q) begin
                    state_d    = ST_RUN;
                    step_req_d = 1'b0;
                end else if (step_req_q) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                // Step presses have no meaning while running.
                step_req_d = 1'b0;
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (!run_s_q) begin
                    state_d = ST_IDLE;
                end else if (bus.tick) begin
                    cpu_en_d = 1'b1;
`ifdef STEP_RUN_CYCLE_LIMIT_EN
                    if ((bus.cycle_limit != '0) &&
                        ((cycle_count_q + CNT_W'(1)) == bus.cycle_limit)) begin
                        state_d = ST_HALTED;
                    end
`endif
                end
            end
            ST_STEP: begin
                if (bus.halt_req) begin
                    state_d    = ST_HALTED;
                    step_req_d = 1'b0;
                end else if (bus.tick) begin
                    cpu_en_d   = 1'b1;
                    step_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_HALTED: begin
                // Leaving requires the operator to release both controls.
                if (!run_s_q && !btn_db) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cycle_count_d = cycle_count_q + CNT_W'(cpu_en_d);
        halted_d      = (state_d == ST_HALTED);
    end

    always_ff @(posedge clock or negedge _rst) begin
        if (!_rst) begin
            run_meta_q    <= 1'b0;
            run_s_q       <= 1'b0;
            state_q       <= ST_IDLE;
            step_req_q    <= 1'b0;
            cpu_en_q      <= 1'b0;
            halted_q      <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            run_meta_q    <= bus.run_sw;
            run_s_q       <= run_meta_q;
            state_q       <= state_d;
            step_req_q    <= step_req_d;
            cpu_en_q      <= cpu_en_d;
            halted_q      <= halted_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.cpu_en      = cpu_en_q;
    assign bus.state       = state_q;
    assign bus.halted      = halted_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: doc/step_run_controller.md
Name: step_run_controller

Overview:
Consumes the one-clock tick from the clock divider and gates the processor's pipeline clock enable. It supports free-run, debounced single-step, and halt modes.
Sits between the divider output and the enable input of the single-cycle/pipelined core.
All state runs on the fast board clock. No derived clocks.

Parameters:
DEB_TICKS, 4, number of consecutive ticks a synchronized step button must differ from its debounced value before the debounced value updates (>=2)
CNT_W, 16, width of the issued-enable counter

Ports:
clock  input  1  board clock; all logic on its rising edge
_rst  input  1  asynchronous active-low reset
tick  input  1  one-clock-wide pulse from the divider
run_sw  input  1  raw run switch level, asynchronous
step_btn  input  1  raw step pushbutton, asynchronous, bouncy
halt_req  input  1  synchronous halt request from core (HALT decoded)
cpu_en  output  1  one-clock enable pulse to core pipeline registers
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED
halted  output  1  high while state==HALTED
cycle_count  output  CNT_W  number of cpu_en pulses issued, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous, active-low. While _rst=0: state=IDLE, cpu_en=0, halted=0, cycle_count=0. Synchronizers, debounce counter, btn_db and step_req are all cleared. Reset asserted mid-operation aborts any pending step.
- run_sw and step_btn each pass through a 2-flop synchronizer; run_s and step_s are the synchronized values.
- Debounce: evaluated only on cycles where tick=1.
  - If step_s != btn_db: deb_cnt increments. When deb_cnt==DEB_TICKS-1, btn_db<=step_s and deb_cnt<=0.
  - If step_s == btn_db: deb_cnt<=0.
  - deb_cnt width is $clog2(DEB_TICKS).
- A rising edge of btn_db sets step_req. step_req stays set until consumed in STEP, or discarded on any transition into RUN or HALTED.
- cpu_en is registered. A qualifying tick in cycle t gives cpu_en=1 in cycle t+1 only.
- cycle_count increments in the same cycle cpu_en is high.
- FSM transitions, evaluated every clock; halt_req has the highest priority in RUN and STEP:
  - IDLE: run_s=1 -> RUN. Otherwise, step_req=1 -> STEP. Otherwise stay in IDLE. Never issues cpu_en.
  - RUN: halt_req=1 -> HALTED, and no cpu_en for a tick in the same cycle. Otherwise, run_s=0 -> IDLE, and no cpu_en for a tick in the same cycle. Otherwise each tick issues cpu_en. Step presses are discarded.
  - STEP: halt_req=1 -> HALTED, and step_req is cleared. Otherwise on the next tick: issue exactly one cpu_en, clear step_req, go to IDLE.
  - HALTED: cpu_en held 0. Exit to IDLE only when run_s=0 and btn_db=0 in the same cycle. halt_req is ignored here.
- halted = (state==HALTED), registered with the state.

Optional Feature:
Macro: STEP_RUN_CYCLE_LIMIT_EN.
- Defined: adds input port cycle_limit [CNT_W-1:0], placed after halt_req. In RUN, if cycle_limit != 0 and a cpu_en would make cycle_count equal cycle_limit, that pulse is issued and the state moves to HALTED in the same edge. cycle_limit=0 disables the limit.
- Undefined: the port is absent, and only halt_req causes HALTED.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_STEP=2'b10, ST_HALTED=2'b11, plus default DEB_TICKS and CNT_W values. The divider and the core's debug readout reuse them.
- One sub-module: btn_debounce (2-flop sync + tick-qualified stable counter, outputs btn_db and a rise pulse). It is instantiated once for step_btn.
- run_sw uses the bare synchronizer only.

Test Plan:
Bench setup: DEB_TICKS=4, CNT_W=16, tick every 4th clock.
1. Async reset: drive _rst=0 mid-RUN between clock edges -> state=00, cpu_en=0, cycle_count=0 immediately. Release _rst -> stays IDLE with run_sw=0.
2. Free run: run_sw=1; after state==01, apply 10 ticks then run_sw=0 -> exactly 10 cpu_en pulses, each one clock after its tick; cycle_count=10; state returns 00.
3. Single step: step_btn high for 6 ticks then low -> exactly one cpu_en, cycle_count+1, state 10 then 00. step_btn toggling every clock for 3 ticks -> no cpu_en, btn_db unchanged.
4. Halt priority: in RUN, assert halt_req in the same cycle as a tick -> no cpu_en, state=11, halted=1. Holding run_sw=1 keeps HALTED. run_sw=0 with btn_db=0 -> IDLE.
5. Wrap: CNT_W=4, 16 run pulses -> cycle_count back to 0, next pulse gives 1.
6. With STEP_RUN_CYCLE_LIMIT_EN, cycle_limit=5, run_sw=1 -> exactly 5 cpu_en pulses, state=11 on the 5th. cycle_limit=0 -> runs unbounded.
